// File: rtl/mux4_rr_arbiter.sv
// Round-robin burst arbiter driving a shared mux4 select with valid/ready beat qualification.
// A burst stays on one requester until its last beat or MAX_BEATS, then priority rotates.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BEATS = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] last,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       out_last,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       err
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]       r_state;
  logic [1:0]       r_owner;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_burst;
  logic             w_req_own;
  logic             w_limit;
  logic             w_accept;
  logic             w_end;
  logic             w_any_req;
  logic [1:0]       w_base;
  logic [1:0]       w_idx;
  logic [1:0]       w_winner;
  logic             w_found;

  assign w_in_burst = (r_state == ST_BURST);
  assign w_req_own  = req[r_owner];
  assign w_limit    = (r_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_any_req  = |req;

  assign out_valid  = w_in_burst & w_req_own;
  assign out_last   = out_valid & (last[r_owner] | w_limit);
  assign w_accept   = out_valid & out_ready;
  assign w_end      = w_accept & out_last;
  assign gnt        = w_accept ? (4'b0001 << r_owner) : 4'b0000;
  assign err        = w_in_burst & ~w_req_own;
  assign busy       = w_in_burst;
  assign sel        = r_owner;

  // Scanning from owner+1 at end of burst leaves the current owner last in line.
  assign w_base = w_in_burst ? (r_owner + 2'd1) : r_ptr;

  always_comb begin
    w_found  = 1'b0;
    w_idx    = w_base;
    w_winner = w_base;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = w_base + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_cnt   <= '0;
            r_state <= ST_BURST;
          end
        end
        default: begin
          if (!w_req_own) begin
            r_ptr   <= r_owner + 2'd1;
            r_state <= ST_IDLE;
          end else if (w_end) begin
            r_ptr <= r_owner + 2'd1;
            if (w_any_req) begin
              r_owner <= w_winner;
              r_cnt   <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with hand-computed expectations (MAX_BEATS=8).
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] last = '0;
  logic       out_ready = 1'b0;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_last;
  logic [3:0] gnt;
  logic       busy;
  logic       err;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_BEATS(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .last     (last),
    .out_ready(out_ready),
    .sel      (sel),
    .out_valid(out_valid),
    .out_last (out_last),
    .gnt      (gnt),
    .busy     (busy),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b1;
    last = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sel",   32'(sel),       32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_gnt",   32'(gnt),       32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_err",   32'(err),       32'd0);

    // 1: single requester, one-beat burst
    do_reset();
    req = 4'b0001; last = 4'b0001; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_busy",  32'(busy),      32'd0);
    cyc();
    @(negedge clk);
    chk("t1_sel",   32'(sel),       32'd0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_gnt",   32'(gnt),       32'h1);
    chk("t1_last",  32'(out_last),  32'd1);
    chk("t1_busy",  32'(busy),      32'd1);
    cyc();
    req = 4'b0000;
    @(negedge clk);
    chk("t1_drop_valid", 32'(out_valid), 32'd0);
    chk("t1_drop_gnt",   32'(gnt),       32'd0);
    cyc();
    @(negedge clk);
    chk("t1_idle_after", 32'(busy), 32'd0);

    // 2: all requesting, single-beat bursts rotate with no bubble
    do_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    cyc();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t2_sel%0d", k),   32'(sel),       32'(k % 4));
      chk($sformatf("t2_gnt%0d", k),   32'(gnt),       32'(1 << (k % 4)));
      chk($sformatf("t2_valid%0d", k), 32'(out_valid), 32'd1);
      cyc();
    end

    // 3: beat limit forces out_last on the 8th beat, then a fresh burst
    do_reset();
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    cyc();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t3_gnt%0d", k),  32'(gnt),      32'h4);
      chk($sformatf("t3_last%0d", k), 32'(out_last), (k == 8) ? 32'd1 : 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("t3_new_sel",  32'(sel),      32'd2);
    chk("t3_new_gnt",  32'(gnt),      32'h4);
    chk("t3_new_last", 32'(out_last), 32'd0);

    // 4: backpressure holds owner 1 and its beat count
    do_reset();
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("t4_first_gnt", 32'(gnt), 32'h2);
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4_hold_valid%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("t4_hold_sel%0d", k),   32'(sel),       32'd1);
      chk($sformatf("t4_hold_gnt%0d", k),   32'(gnt),       32'd0);
      cyc();
    end
    out_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("t4_last%0d", k), 32'(out_last), (k == 8) ? 32'd1 : 32'd0);
      cyc();
    end

    // 5: owner 3 aborts after 2 beats
    do_reset();
    req = 4'b1000; last = 4'b0000; out_ready = 1'b1;
    cyc();
    repeat (2) begin
      @(negedge clk);
      chk("t5_beat_gnt", 32'(gnt), 32'h8);
      cyc();
    end
    req = 4'b0000;
    @(negedge clk);
    chk("t5_err",   32'(err),  32'd1);
    chk("t5_gnt",   32'(gnt),  32'd0);
    chk("t5_busy",  32'(busy), 32'd1);
    cyc();
    req = 4'b1111;
    @(negedge clk);
    chk("t5_err_gone", 32'(err),  32'd0);
    chk("t5_idle",     32'(busy), 32'd0);
    cyc();
    @(negedge clk);
    chk("t5_ptr_sel", 32'(sel), 32'd0);

    // 6: reset mid-burst of owner 2 at beat 4
    do_reset();
    req = 4'b0100; last = 4'b0000; out_ready = 1'b1;
    cyc();
    repeat (3) cyc();
    @(negedge clk);
    chk("t6_pre_sel", 32'(sel), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_sel",   32'(sel),       32'd0);
    chk("t6_rst_busy",  32'(busy),      32'd0);
    cyc();
    rst_n = 1'b1;
    req = 4'b0110;
    @(negedge clk);
    chk("t6_idle", 32'(busy), 32'd0);
    cyc();
    @(negedge clk);
    chk("t6_win_sel", 32'(sel), 32'd1);
    chk("t6_win_gnt", 32'(gnt), 32'h2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
